melody_writer: RTL and testbench
================================

// Module: melody_writer
// PURPOSE
//  Producer side of the game's melody-load interface. Generates a pseudo-random
//  8-note melody and packs it into the 32-bit answer word. Delivers the word
//  with a one-cycle write_enable, then issues game_start and waits for
//  game_end. Sits between the top-level start button and the game module's
//  data_in/write_enable/game_start/game_end ports.
// PARAMETERS
//  NUM_NOTES  8         notes per melody; fixed at 8 for the 32-bit word
//  SEED       16'hACE1  LFSR value after reset; must be non-zero
//  START_GAP  4         clk cycles from write_enable to game_start (>=1)
//  NO_REPEAT  1         1: reject a note equal to the previous note
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  new_game     in   1   single-cycle request to generate and load a melody
//  game_end     in   1   level from game module; high when the round is finished
//  seed_load    in   1   synchronous load of seed_in into the LFSR
//  seed_in      in   16  LFSR seed; a value of 0 loads SEED instead
//  data_out     out  32  packed melody; note i at [4i+2:4i]; bit 4i+3 is always 0
//  write_enable out  1   one-cycle pulse; data_out is valid in that cycle
//  game_start   out  1   one-cycle pulse START_GAP cycles after write_enable
//  busy         out  1   high in GEN, WRITE, GAP, START and PLAY
//  round_count  out  8   completed rounds; saturates at 255
// BEHAVIOUR
//  Reset: data_out=0, write_enable=0, game_start=0, busy=0, round_count=0,
//   lfsr=SEED, state=IDLE, note index=0. Reset mid-operation aborts with no pulses.
//  LFSR: 16-bit Galois, mask 16'hB400. Shift right; if the old bit0 is 1,
//   XOR the mask in. Free-running: it advances every cycle, including IDLE.
//   seed_load has priority over advance in the same cycle.
//  FSM: IDLE -> GEN -> WRITE -> GAP -> START -> PLAY -> DONE.
//   IDLE/DONE: new_game=1 -> GEN with idx=0. Shadow word is cleared.
//    new_game is ignored in all other states.
//   GEN: each cycle, candidate = lfsr[2:0] (current value, pre-advance).
//    If NO_REPEAT && idx!=0 && candidate==prev, the candidate is rejected and
//     idx holds.
//    Otherwise store the candidate at shadow[4*idx +: 3] and set prev=candidate.
//    If idx==7 -> WRITE; otherwise idx++.
//    Minimum GEN time is 8 cycles. Note 0 is always accepted.
//   WRITE (1 cycle): data_out<=shadow (registered, visible next cycle).
//    write_enable=1 in the cycle data_out first shows the new word.
//    data_out then holds until the next WRITE.
//   GAP: counts START_GAP-1 cycles. START: game_start=1 for 1 cycle -> PLAY.
//    Net result: game_start rises exactly START_GAP cycles after write_enable.
//   PLAY: rising edge of game_end (registered prev sample) -> DONE and
//    round_count++ (saturate at 8'hFF). A game_end already high at PLAY entry
//    does not count until it falls and rises again.
//   DONE: busy=0. Behaves as IDLE, but round_count is retained.
//  All outputs are registered. write_enable and game_start never assert
//   together.
// TESTING
//  1 reset mid-GEN (idx=4) -> next cycle all outputs 0, state IDLE, no
//    write_enable ever seen.
//  2 seed_load=1, seed_in=0 -> lfsr==16'hACE1. seed_in=16'h0001 -> next
//    advance gives 16'hB400.
//  3 seed_load 16'h0001, then new_game next cycle, NO_REPEAT=0 ->
//    write_enable after exactly 9 cycles; data_out matches the LFSR model;
//    data_out & 32'h88888888 == 0.
//  4 NO_REPEAT=1, 50 seeded games -> no adjacent equal 3-bit notes;
//    game_start exactly START_GAP(4) cycles after each write_enable.
//  5 new_game pulsed in GEN, GAP and PLAY -> ignored (single write_enable).
//    game_end held high entering PLAY -> no count until it toggles 0->1.
//  6 run 256 rounds (new_game, game_end pulse) -> round_count stays 255;
//    busy low in DONE; new_game from DONE starts a new GEN.

Source files
------------

// File: rtl/melody_writer.sv
// Melody producer for the game's load interface: builds an 8-note pseudo-random melody
// from a free-running Galois LFSR, writes it as one 32-bit word, then starts the round.
module melody_writer #(
    parameter int          NUM_NOTES = 8,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          START_GAP = 4,
    parameter bit          NO_REPEAT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        game_end,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    output logic [31:0] data_out,
    output logic        write_enable,
    output logic        game_start,
    output logic        busy,
    output logic [7:0]  round_count
);

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [2:0]  LAST_IDX  = 3'(NUM_NOTES - 1);
    // Terminal GAP count; only meaningful when START_GAP >= 2.
    localparam logic [7:0]  GAP_LAST  = 8'(START_GAP - 2);

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        WRITE,
        GAP,
        START,
        PLAY,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [2:0]  idx;
    logic [2:0]  prev_note;
    logic [31:0] shadow;
    logic [7:0]  gap_cnt;
    logic        game_end_q;

    logic [2:0]  candidate;
    logic        reject;

    assign candidate = lfsr[2:0];
    assign reject    = NO_REPEAT && (idx != 3'd0) && (candidate == prev_note);

    // Free-running generator; a zero seed would lock the LFSR, so it maps to SEED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (seed_load) begin
            lfsr <= (seed_in == 16'h0000) ? SEED : seed_in;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= 3'd0;
            prev_note    <= 3'd0;
            shadow       <= 32'h0;
            gap_cnt      <= 8'd0;
            game_end_q   <= 1'b0;
            data_out     <= 32'h0;
            write_enable <= 1'b0;
            game_start   <= 1'b0;
            busy         <= 1'b0;
            round_count  <= 8'd0;
        end else begin
            // NOTE: pulse outputs default low here so every state only has to raise them.
            write_enable <= 1'b0;
            game_start   <= 1'b0;
            // Sampled in every state so a level already high at PLAY entry is not an edge.
            game_end_q   <= game_end;

            case (state)
                IDLE, DONE: begin
                    if (new_game) begin
                        state  <= GEN;
                        idx    <= 3'd0;
                        shadow <= 32'h0;
                        busy   <= 1'b1;
                    end
                end
                GEN: begin
                    if (!reject) begin
                        shadow[{idx, 2'b00} +: 3] <= candidate;
                        prev_note <= candidate;
                        if (idx == LAST_IDX) begin
                            state <= WRITE;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    data_out     <= shadow;
                    write_enable <= 1'b1;
                    gap_cnt      <= 8'd0;
                    state        <= (START_GAP > 1) ? GAP : START;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= START;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                START: begin
                    game_start <= 1'b1;
                    state      <= PLAY;
                end
                PLAY: begin
                    if (game_end && !game_end_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        if (round_count != 8'hFF) begin
                            round_count <= round_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_melody_writer.sv
// Scoreboard bench for melody_writer: a reference model predicts each melody word and
// its write_enable cycle; a negedge monitor checks every pulse the DUT presents.
module tb_melody_writer;

    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          START_GAP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_game = 1'b0;
    logic        game_end = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic [31:0] data_out;
    logic        write_enable;
    logic        game_start;
    logic        busy;
    logic [7:0]  round_count;

    melody_writer #(
        .NUM_NOTES(8),
        .SEED     (SEED),
        .START_GAP(START_GAP),
        .NO_REPEAT(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .new_game    (new_game),
        .game_end    (game_end),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .data_out    (data_out),
        .write_enable(write_enable),
        .game_start  (game_start),
        .busy        (busy),
        .round_count (round_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int rc_model = 0;

    typedef struct {
        logic [31:0] word;
        int          we_cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference melody: walk the LFSR sequence one value per GEN cycle, skipping repeats.
    task automatic gen_melody(input logic [15:0] s, output logic [31:0] word, output int n);
        logic [15:0] l;
        logic [2:0]  c;
        logic [2:0]  prev;
        int          k;
        l = s;
        k = 0;
        n = 0;
        prev = 3'd0;
        word = 32'h0;
        while (k < 8 && n < 1000) begin
            l = lfsr_next(l);
            n++;
            c = l[2:0];
            if (k == 0 || c != prev) begin
                word[4*k +: 3] = c;
                prev = c;
                k++;
            end
        end
    endtask

    // Monitor
    exp_t mon_e;
    int   gs_due = 0;
    bit   gs_pending = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            gs_pending = 1'b0;
        end else begin
            if (write_enable) begin
                check("we_gs_overlap", {31'b0, game_start}, 32'd0);
                check("we_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    int reps;
                    mon_e = exp_q.pop_front();
                    check("we_cycle", cyc, mon_e.we_cyc);
                    check("melody_word", data_out, mon_e.word);
                    check("pad_bits", data_out & 32'h88888888, 32'h0);
                    reps = 0;
                    for (int i = 1; i < 8; i++) begin
                        if (data_out[4*i +: 3] == data_out[4*(i-1) +: 3]) reps++;
                    end
                    check("adjacent_repeats", reps, 32'd0);
                end
                gs_due = cyc + START_GAP;
                gs_pending = 1'b1;
            end
            if (game_start) begin
                check("gs_expected", {31'b0, gs_pending}, 32'd1);
                check("gs_cycle", cyc, gs_due);
                gs_pending = 1'b0;
            end else if (gs_pending && cyc >= gs_due) begin
                check("gs_missing", {31'b0, game_start}, 32'd1);
                gs_pending = 1'b0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, data_out, 32'h0);
        check({tag, "_we"}, {31'b0, write_enable}, 32'd0);
        check({tag, "_gs"}, {31'b0, game_start}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_rc"}, {24'b0, round_count}, 32'd0);
    endtask

    // One full round. from_reset: caller holds reset at a negedge; release and request together.
    task automatic play_round(input bit from_reset, input logic [15:0] sv,
                              input bit extra_ng, input bit hold_end);
        logic [15:0] s;
        logic [31:0] w;
        int          n;
        bit          seen;
        if (from_reset) begin
            s = SEED;
            reset = 1'b0;
        end else begin
            @(negedge clk);
            seed_load = 1'b1;
            seed_in = sv;
            s = (sv == 16'h0000) ? SEED : sv;
            @(negedge clk);
            seed_load = 1'b0;
        end
        new_game = 1'b1;
        gen_melody(s, w, n);
        exp_q.push_back('{w, cyc + 1 + n + 1});
        @(negedge clk);
        new_game = 1'b0;
        check("busy_gen", {31'b0, busy}, 32'd1);

        if (extra_ng) begin
            @(negedge clk);
            new_game = 1'b1;
            @(negedge clk);
            new_game = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                if (write_enable) seen = 1'b1;
                else @(negedge clk);
            end
            check("we_seen", {31'b0, seen}, 32'd1);
            new_game = 1'b1;
            @(negedge clk);
            new_game = 1'b0;
        end

        if (hold_end) game_end = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (game_start) seen = 1'b1;
            else @(negedge clk);
        end
        check("gs_seen", {31'b0, seen}, 32'd1);

        if (extra_ng) begin
            new_game = 1'b1;
            @(negedge clk);
            new_game = 1'b0;
        end

        if (hold_end) begin
            repeat (3) @(negedge clk);
            check("rc_held", {24'b0, round_count}, rc_model);
            check("busy_play", {31'b0, busy}, 32'd1);
            game_end = 1'b0;
            @(negedge clk);
        end

        game_end = 1'b1;
        @(negedge clk);
        game_end = 1'b0;
        rc_model = (rc_model < 255) ? rc_model + 1 : 255;

        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (!busy) seen = 1'b1;
            else @(negedge clk);
        end
        check("busy_done", {31'b0, busy}, 32'd0);
        check("round_count", {24'b0, round_count}, rc_model);
        check("data_hold", data_out, w);
    endtask

    task automatic reset_mid_gen();
        @(negedge clk);
        seed_load = 1'b1;
        seed_in = 16'($urandom_range(1, 65535));
        @(negedge clk);
        seed_load = 1'b0;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        check_all_zero("rst_next");
        rc_model = 0;
        play_round(1'b1, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");

        play_round(1'b1, 16'h0000, 1'b0, 1'b0);   // melody from the reset seed
        play_round(1'b0, 16'h0000, 1'b0, 1'b0);   // zero seed maps to SEED
        play_round(1'b0, 16'h0001, 1'b0, 1'b0);
        play_round(1'b0, 16'hBEEF, 1'b1, 1'b0);   // new_game in GEN, GAP, PLAY
        play_round(1'b0, 16'h1234, 1'b0, 1'b1);   // game_end high entering PLAY

        reset_mid_gen();

        for (int r = 0; r < 260; r++) begin
            logic [15:0] sv;
            sv = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
            play_round(1'b0, sv, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        check("rc_saturated", {24'b0, round_count}, 32'd255);

        repeat (10) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
